// File: rtl/demux_pkg.sv
// Shared widths and FSM state encoding for the 1-to-8 demux / serial capture unit.
package demux_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/demux_bit_counter.sv
// Frame bit counter: clear dominates enable; tc flags the last bit position of a frame.
module demux_bit_counter
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            // Natural 7->0 wrap; the FSM only enables on tc when the frame is completing.
            count <= count + SEL_W'(1);
        end
    end

    assign tc = (count == '1);

endmodule

// File: rtl/demux_one_to_eight.sv
// Registered 1-to-8 demux with serial byte capture, LSB first.
// Define DEMUX_PARITY_EN to append an even-parity bit to every frame.
module demux_one_to_eight
    import demux_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_VALUE = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic [SEL_W-1:0]  select,
    input  logic              wr_en,
    input  logic              start,
    input  logic              in_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              parity_err
);

    state_t            state;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] next_shadow;
    logic [SEL_W-1:0]  count;
    logic              tc;
    logic              cnt_en;

    // start clears the counter from any state; a start cycle never advances it.
    assign cnt_en = (state == SHIFT) && in_valid && !start;

    demux_bit_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (cnt_en),
        .count (count),
        .tc    (tc)
    );

    // Shadow with the current bit merged, so the 8th bit lands in data_out on the same edge.
    always_comb begin
        next_shadow        = shadow;
        next_shadow[count] = din;
    end

`ifdef DEMUX_PARITY_EN
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            data_out  <= RESET_VALUE;
            out_valid <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow <= '0;
                        state  <= SHIFT;
                    end else if (wr_en) begin
                        data_out[select] <= din;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        shadow <= '0;
                    end else if (in_valid) begin
                        shadow <= next_shadow;
                        if (tc) begin
`ifdef DEMUX_PARITY_EN
                            state     <= PARITY;
`else
                            data_out  <= next_shadow;
                            out_valid <= 1'b1;
                            state     <= IDLE;
`endif
                        end
                    end
                end
                PARITY: begin
`ifdef DEMUX_PARITY_EN
                    if (start) begin
                        shadow <= '0;
                        state  <= SHIFT;
                    end else if (in_valid) begin
                        // Loaded regardless of the check; consumers qualify with parity_err.
                        data_out  <= shadow;
                        out_valid <= 1'b1;
                        par_err_q <= (^shadow) ^ din;
                        state     <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
